// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: bus writes feed a small byte FIFO that a
// shifter drains onto tx; STATUS and DIVISOR are readable over the same bus.
module mmio_uart_tx #(
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [15:0] DIVISOR_RESET = 16'd16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  address,
    inout  wire  [15:0] data,
    input  logic        notRead,
    input  logic        notWrite,
    input  logic        notCS,
    output logic        tx
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic             nwr_q, nwr_d;
    logic             nrd_q, nrd_d;
    logic [15:0]      div_q, div_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       mem [FIFO_DEPTH];

    state_e      state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_q;
    logic [15:0] cyc_q;
    logic [15:0] dlat_q;
    logic        tx_q;

    logic        write_stb, status_rd_stb;
    logic        full, empty, busy;
    logic        push_req, push_ok, pop;
    logic        bit_done;
    logic        rd_en;
    logic [15:0] rdata;
    logic [15:0] eff_div;

    // Strobes fire only on the first edge of a low pulse, so a long strobe acts once.
    assign write_stb     = !notCS && !notWrite && nwr_q;
    assign status_rd_stb = !notCS && !notRead && nrd_q && (address == REG_STATUS);

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign busy     = (state_q != IDLE);
    assign push_req = write_stb && (address == REG_TXDATA);
    assign push_ok  = push_req && !full;
    assign pop      = (state_q == IDLE) && !empty;
    assign eff_div  = (div_q == '0) ? 16'd1 : div_q;
    assign bit_done = (cyc_q == dlat_q - 16'd1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        nwr_d     = notWrite;
        nrd_d     = notRead;
        div_d     = div_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        overrun_d = overrun_q;
        count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);

        if (write_stb && (address == REG_DIVISOR)) begin
            div_d = data;
        end
        if (push_ok) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        // A dropped push outranks a status read landing on the same edge.
        if (status_rd_stb) begin
            overrun_d = 1'b0;
        end
        if (push_req && full) begin
            overrun_d = 1'b1;
        end
    end

    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            nwr_q     <= 1'b1;
            nrd_q     <= 1'b1;
            div_q     <= DIVISOR_RESET;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            nwr_q     <= nwr_d;
            nrd_q     <= nrd_d;
            div_q     <= div_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count and pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wptr_q] <= data[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            shift_q <= '0;
            bit_q   <= '0;
            cyc_q   <= '0;
            dlat_q  <= 16'd1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q  <= 1'b1;
                    cyc_q <= '0;
                    bit_q <= '0;
                    if (pop) begin
                        shift_q <= mem[rptr_q];
                        dlat_q  <= eff_div;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        cyc_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        cyc_q <= cyc_q + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cyc_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        cyc_q <= cyc_q + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cyc_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cyc_q <= cyc_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx = tx_q;

    // A simultaneous write wins the bus, so reads drive only while notWrite is high.
    assign rd_en = !notCS && !notRead && notWrite;

    always_comb begin
        rdata = '0;
        case (address)
            REG_STATUS:  rdata = {8'h00, 4'(count_q), overrun_q, busy, empty, full};
            REG_DIVISOR: rdata = div_q;
            default:     rdata = '0;
        endcase
    end

    assign data = rd_en ? rdata : 16'bz;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped serial transmitter. Acts as a bus responder to the cpu's address/data/memNotRead/memNotWrite bus.
- Sits beside the sram on the shared bus and is selected by an external active-low chip select.
- Accepts bytes by bus write into a small FIFO, serializes them 8N1 (LSB first) on `tx`, and exposes status and divisor registers for bus reads.
- Provides console output for programs running on the cpu.

Parameters:
- FIFO_DEPTH, 4, number of byte entries in the TX FIFO; a power of two, at least 2.
- DIVISOR_RESET, 16, reset value of the baud divisor (clock cycles per serial bit).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  2  register select, taken from the low bus address bits.
- data  inout  16  shared bus data; driven only during a selected read, high-Z otherwise.
- notRead  input  1  active-low bus read strobe.
- notWrite  input  1  active-low bus write strobe.
- notCS  input  1  active-low chip select.
- tx  output  1  serial line; idles high.

Behaviour:
- Register map, selected by address:
  - 0 TXDATA: write-only; data[7:0] is pushed to the FIFO; reads return 0.
  - 1 STATUS: read-only. Bit 0 = full, bit 1 = empty, bit 2 = busy (shifter not IDLE), bit 3 = overrun (sticky). Bits [7:4] = FIFO count. Other bits 0.
  - 2 DIVISOR: read/write, 16 bits.
  - 3: reads 0; writes ignored.
- Read path:
  - data is driven combinationally when notCS=0 and notRead=0; otherwise high-Z.
  - If notRead and notWrite are both low, the write takes effect and data stays high-Z.
- Write detect:
  - notWrite is registered once per clock.
  - A write is accepted on the single clock edge where notCS=0, notWrite=0, and the registered notWrite=1.
  - A long strobe therefore produces exactly one push.
  - data is sampled on that same edge.
- Read side effect: the overrun bit clears on the first edge of a STATUS read (notRead falling, detected the same way as writes).
- Reset:
  - Synchronous; on the edge where reset=1: FIFO emptied, count=0, overrun=0, DIVISOR=DIVISOR_RESET, state=IDLE, tx=1.
  - A reset mid-frame aborts the frame; tx is high from the following cycle.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo FIFO_DEPTH.
  - A push when count==FIFO_DEPTH is dropped and sets overrun. Fullness is judged before any pop on the same edge.
  - A simultaneous push (not full) and pop leaves count unchanged.
- Shifter FSM (IDLE, START, DATA, STOP):
  - IDLE: tx=1. If the FIFO is non-empty: pop into the shift register, latch the effective divisor, go to START.
  - START: tx=0 for D cycles.
  - DATA: tx=shift[0] for D cycles per bit, 8 bits, LSB first; a bit counter runs 0..7.
  - STOP: tx=1 for D cycles, then IDLE.
  - D = latched divisor, with 0 treated as 1. A DIVISOR write during a frame affects only the next frame.
- Timing:
  - A push on edge N into an idle, empty block makes tx go low from edge N+1.
  - Frame length is exactly 10·D cycles.
  - Back-to-back frames have one IDLE cycle between STOP and the next START (period 10·D+1).
- busy is 1 in START, DATA and STOP.

Test Plan:
- Reset → tx=1. STATUS read returns 0x0002. DIVISOR read returns 16. data is high-Z while notRead=1.
- DIVISOR=4, write 0xA5 to TXDATA → tx low for 4 cycles starting one edge after the write. Then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop high for 4. Total 40 cycles. STATUS busy=1 during the frame.
- Hold notWrite low for 10 cycles with a single write of 0x41 → exactly one frame sent; count never exceeds 1.
- DIVISOR=100, five writes in quick succession → first pops immediately, next four fill the FIFO (STATUS=0x0045 after the fourth). The fifth is dropped, giving overrun: STATUS=0x004D. The next STATUS read clears bit 3.
- Write DIVISOR=2 mid-frame at D=8 → the current frame keeps 8-cycle bits; the next frame uses 2-cycle bits. DIVISOR=0 gives 1-cycle bits.
- Assert reset during DATA of a frame with 2 bytes queued → tx=1 next cycle, STATUS=0x0002, no further frames.
